// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - architectural register file with per-register pending-write scoreboard
//
// Two combinational read ports serve decode, one write port serves writeback.
// Each register r != 0 has a saturating outstanding-write counter: decode
// reserves rd on issue (increment), writeback releases it (decrement).
//
// Optional build macro: REGFILE_BYPASS_EN (write-through forwarding of the
// writeback port onto the read ports in the same cycle).
//
// Ports:
//   clk_in, rst_in              clock (rising edge), async active-high reset
//   rdy_in                      global enable; low freezes all state
//   read_flag_n/reg_read_n      read port n enable and index (n = 1, 2)
//   read_data_n/pending_n       read port n data and outstanding-write flag
//   issue_flag/issue_rd         reserve destination issue_rd
//   issue_full                  issue_rd counter saturated; issue is dropped
//   wb_flag/wb_addr/wb_data     writeback write port

module reg_file_sb #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int PEND_W = 2
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              read_flag_1,
    input  logic [ADDR_W-1:0] reg_read_1,
    output logic [DATA_W-1:0] read_data_1,
    output logic              pending_1,
    input  logic              read_flag_2,
    input  logic [ADDR_W-1:0] reg_read_2,
    output logic [DATA_W-1:0] read_data_2,
    output logic              pending_2,
    input  logic              issue_flag,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic              issue_full,
    input  logic              wb_flag,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data
);

    localparam int NREG = 1 << ADDR_W;
    localparam logic [PEND_W-1:0] CNT_MAX = '1;
    localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [PEND_W-1:0] cnt_q  [NREG];
    logic [PEND_W-1:0] cnt_d  [NREG];

    logic wb_en;
    logic full_raw;
    logic issue_ok;
    logic inc_r;
    logic dec_r;

    assign wb_en    = rdy_in && wb_flag && (wb_addr != '0);
    assign full_raw = issue_flag && (issue_rd != '0) && (cnt_q[issue_rd] == CNT_MAX);
    // Outputs are forced quiet while reset is held, independent of stored state.
    assign issue_full = !rst_in && full_raw;
    assign issue_ok   = issue_flag && (issue_rd != '0) && !full_raw;

    always_comb begin
        read_data_1 = '0;
        pending_1   = 1'b0;
        if (!rst_in && read_flag_1) begin
            read_data_1 = regs_q[reg_read_1];
            pending_1   = (cnt_q[reg_read_1] != '0);
`ifdef REGFILE_BYPASS_EN
            if (wb_en && (wb_addr == reg_read_1)) begin
                read_data_1 = wb_data;
                // The last outstanding write is landing now, so it no longer blocks.
                if (cnt_q[reg_read_1] == CNT_ONE) begin
                    pending_1 = 1'b0;
                end
            end
`endif
        end
    end

    always_comb begin
        read_data_2 = '0;
        pending_2   = 1'b0;
        if (!rst_in && read_flag_2) begin
            read_data_2 = regs_q[reg_read_2];
            pending_2   = (cnt_q[reg_read_2] != '0);
`ifdef REGFILE_BYPASS_EN
            if (wb_en && (wb_addr == reg_read_2)) begin
                read_data_2 = wb_data;
                if (cnt_q[reg_read_2] == CNT_ONE) begin
                    pending_2 = 1'b0;
                end
            end
`endif
        end
    end

    // Register 0 is hardwired: its data and counter never leave zero.
    always_comb begin
        inc_r     = 1'b0;
        dec_r     = 1'b0;
        regs_d[0] = '0;
        cnt_d[0]  = '0;
        for (int r = 1; r < NREG; r++) begin
            regs_d[r] = regs_q[r];
            cnt_d[r]  = cnt_q[r];
            if (wb_en && (wb_addr == ADDR_W'(r))) begin
                regs_d[r] = wb_data;
            end
            inc_r = issue_ok && (issue_rd == ADDR_W'(r));
            // A writeback with nothing outstanding still writes data but never underflows.
            dec_r = wb_flag && (wb_addr == ADDR_W'(r)) && (cnt_q[r] != '0);
            if (inc_r && !dec_r) begin
                cnt_d[r] = cnt_q[r] + CNT_ONE;
            end else if (dec_r && !inc_r) begin
                cnt_d[r] = cnt_q[r] - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
        end else if (rdy_in) begin
            regs_q <= regs_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule
